// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: two request channels and
// two response channels. The master modport is the requester side, the slave
// modport is the arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 6,
  parameter int unsigned FLAG_W = 5
) ();

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [SEL_W-1:0]  req0_sel;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic [FLAG_W-1:0] rsp0_flags;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [SEL_W-1:0]  req1_sel;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic [FLAG_W-1:0] rsp1_flags;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
    output req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, rsp0_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_flags,
    input  req1_valid, req1_a, req1_b, req1_sel, rsp1_ready,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_flags
  );

endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared ALU and PSR.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold
// response until consumed). ALU operand/select registers hold their value in
// every state so the PSR re-latches identical flags while idle.
module alu_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned SEL_W  = 6,
  parameter int unsigned FLAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [SEL_W-1:0]  alu_sel_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [FLAG_W-1:0] alu_flags_i,
  output logic [15:0]       op_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
  logic [FLAG_W-1:0] rsp0_flags_q, rsp0_flags_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
  logic [FLAG_W-1:0] rsp1_flags_q, rsp1_flags_d;
  logic [15:0]       op_count_q, op_count_d;

  logic grant0;
  logic grant1;
  logic rsp_hs;

  // Round-robin grant: requester 0 wins unless 1 also wants it and 0 went last.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1 = bus.req1_valid & ~grant0;
    rsp_hs = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  assign bus.req0_ready  = (state_q == IDLE) & grant0;
  assign bus.req1_ready  = (state_q == IDLE) & grant1;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp0_flags  = rsp0_flags_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.rsp1_flags  = rsp1_flags_q;
  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign alu_sel_o       = alu_sel_q;
  assign op_count_o      = op_count_q;

  // Next-state and datapath updates; everything holds unless the FSM acts.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_sel_d     = alu_sel_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_flags_d  = rsp0_flags_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_flags_d  = rsp1_flags_q;
    op_count_d    = op_count_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          alu_a_d      = bus.req0_a;
          alu_b_d      = bus.req0_b;
          alu_sel_d    = bus.req0_sel;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (grant1) begin
          alu_a_d      = bus.req1_a;
          alu_b_d      = bus.req1_b;
          alu_sel_d    = bus.req1_sel;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          rsp1_result_d = alu_result_i;
          rsp1_flags_d  = alu_flags_i;
          rsp1_valid_d  = 1'b1;
        end else begin
          rsp0_result_d = alu_result_i;
          rsp0_flags_d  = alu_flags_i;
          rsp0_valid_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          if (owner_q) rsp1_valid_d = 1'b0;
          else         rsp0_valid_d = 1'b0;
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_sel_q     <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_flags_q  <= '0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_flags_q  <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_flags_q  <= rsp0_flags_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_flags_q  <= rsp1_flags_d;
      op_count_q    <= op_count_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives alu_result_i/alu_flags_i
// from the DUT's registered operands; expected responses are queued at accept
// and compared when the response appears.
module tb_alu_arbiter;

  localparam logic [5:0] SEL_ADD = 6'd0;
  localparam logic [5:0] SEL_SUB = 6'd1;
  localparam logic [5:0] SEL_AND = 6'd2;
  localparam logic [5:0] SEL_OR  = 6'd3;
  localparam logic [5:0] SEL_XOR = 6'd4;
  localparam logic [5:0] SEL_CMP = 6'd5;

  typedef struct packed {
    logic        port;
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] alu_a_o, alu_b_o, alu_result_i, op_count_o;
  logic [5:0]  alu_sel_o;
  logic [4:0]  alu_flags_i;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_arbiter_if bus ();

  alu_arbiter #(.DATA_W(16), .SEL_W(6), .FLAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_sel_o    (alu_sel_o),
    .alu_result_i (alu_result_i),
    .alu_flags_i  (alu_flags_i),
    .op_count_o   (op_count_o)
  );

  always #5 clk = ~clk;

  // {flags, result}; flags = {parity, carry, negative, zero, lsb}
  function automatic logic [20:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [5:0] sel);
    logic [16:0] w;
    logic [15:0] r;
    case (sel)
      SEL_ADD:          w = {1'b0, a} + {1'b0, b};
      SEL_SUB, SEL_CMP: w = {1'b0, a} - {1'b0, b};
      SEL_AND:          w = {1'b0, a & b};
      SEL_OR:           w = {1'b0, a | b};
      SEL_XOR:          w = {1'b0, a ^ b};
      default:          w = {1'b0, a};
    endcase
    r = w[15:0];
    return {^r, w[16], r[15], (r == 16'h0000), r[0], r};
  endfunction

  logic [20:0] alu_out;
  always_comb begin
    alu_out      = alu_model(alu_a_o, alu_b_o, alu_sel_o);
    alu_result_i = alu_out[15:0];
    alu_flags_i  = alu_out[20:16];
  end

  task automatic set_req(input int p, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [5:0] s);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = s;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = s;
    end
  endtask

  task automatic push_exp(input int p, input logic [15:0] a, input logic [15:0] b,
                          input logic [5:0] s);
    logic [20:0] m;
    exp_t e;
    m = alu_model(a, b, s);
    e.port = (p != 0);
    e.res  = m[15:0];
    e.flg  = m[20:16];
    sb.push_back(e);
  endtask

  task automatic take_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = '0;
    if (ok) e = sb.pop_front();
  endtask

  task automatic apply_reset();
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    rst = 1'b0;
    #1;
    checks++; if (op_count_o !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=0000", op_count_o); end
    checks++; if ({alu_a_o, alu_b_o, alu_sel_o} !== 38'h0) begin failures++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_a_o, alu_b_o, alu_sel_o); end
    checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    checks++; if ({bus.rsp0_result, bus.rsp0_flags, bus.rsp1_result, bus.rsp1_flags} !== 42'h0) begin failures++; $display("FAIL reset_rsp_data got nonzero exp=0"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL idle_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready}); end
  endtask

  task automatic test_single_add();
    exp_t e; bit ok; logic [4:0] exec_flags;
    apply_reset();
    set_req(0, 1'b1, 16'hDEAD, 16'hCAFE, SEL_ADD);
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL add_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    push_exp(0, 16'hDEAD, 16'hCAFE, SEL_ADD);
    @(negedge clk);
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    #1;
    exec_flags = alu_flags_i;
    checks++; if ({alu_a_o, alu_b_o, alu_sel_o} !== {16'hDEAD, 16'hCAFE, SEL_ADD}) begin failures++; $display("FAIL add_alu_regs got=%h/%h/%h exp=dead/cafe/%h", alu_a_o, alu_b_o, alu_sel_o, SEL_ADD); end
    checks++; if (bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_early_valid got=%b exp=0", bus.rsp0_valid); end
    @(negedge clk);
    take_exp(e, ok);
    checks++; if (!ok || bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== e.res || bus.rsp0_flags !== e.flg) begin failures++; $display("FAIL add_rsp got v=%b %h/%h exp v=1 %h/%h", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, e.res, e.flg); end
    checks++; if (bus.rsp0_result !== 16'hA9AB || bus.rsp0_flags !== exec_flags) begin failures++; $display("FAIL add_const got=%h/%h exp=a9ab/%h", bus.rsp0_result, bus.rsp0_flags, exec_flags); end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    checks++; if (bus.rsp0_valid !== 1'b0 || op_count_o !== 16'd1) begin failures++; $display("FAIL add_done got v=%b cnt=%0d exp v=0 cnt=1", bus.rsp0_valid, op_count_o); end
  endtask

  task automatic test_contention();
    exp_t e; bit ok;
    apply_reset();
    set_req(0, 1'b1, 16'h10AF, 16'hBEEF, SEL_XOR);
    set_req(1, 1'b1, 16'hBAAD, 16'hC0DE, SEL_AND);
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL cont_first_grant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    push_exp(0, 16'h10AF, 16'hBEEF, SEL_XOR);
    @(negedge clk);
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    #1;
    checks++; if (bus.req1_ready !== 1'b0) begin failures++; $display("FAIL cont_exec_ready got=%b exp=0", bus.req1_ready); end
    @(negedge clk);
    take_exp(e, ok);
    checks++; if (!ok || e.port !== 1'b0 || bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== e.res || bus.rsp0_flags !== e.flg || bus.rsp0_result !== 16'hAE40) begin failures++; $display("FAIL cont_rsp0 got v=%b %h/%h exp v=1 ae40/%h", bus.rsp0_valid, bus.rsp0_result, bus.rsp0_flags, e.flg); end
    checks++; if (bus.rsp1_valid !== 1'b0 || bus.rsp1_result !== 16'h0 || bus.rsp1_flags !== 5'h0) begin failures++; $display("FAIL cont_rsp1_untouched got v=%b %h/%h exp v=0 0000/00", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags); end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL cont_second_grant got=%b exp=1", bus.req1_ready); end
    push_exp(1, 16'hBAAD, 16'hC0DE, SEL_AND);
    @(negedge clk);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    @(negedge clk);
    take_exp(e, ok);
    checks++; if (!ok || e.port !== 1'b1 || bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== e.res || bus.rsp1_flags !== e.flg || bus.rsp1_result !== 16'h808C) begin failures++; $display("FAIL cont_rsp1 got v=%b %h/%h exp v=1 808c/%h", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, e.flg); end
    checks++; if (bus.rsp0_result !== 16'hAE40) begin failures++; $display("FAIL cont_rsp0_kept got=%h exp=ae40", bus.rsp0_result); end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    checks++; if (op_count_o !== 16'd2) begin failures++; $display("FAIL cont_count got=%0d exp=2", op_count_o); end
  endtask

  task automatic test_round_robin();
    logic [15:0] a[2], b[2];
    logic [5:0]  s[2];
    int order[4], cyc[4];
    int accepts = 0, resps = 0, pend = -1;
    exp_t e; bit ok;
    apply_reset();
    for (int p = 0; p < 2; p++) begin
      a[p] = 16'($urandom); b[p] = 16'($urandom); s[p] = 6'($urandom_range(0, 5));
      set_req(p, 1'b1, a[p], b[p], s[p]);
    end
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int c = 0; c < 40 && resps < 4; c++) begin
      if (pend >= 0) begin
        a[pend] = 16'($urandom); b[pend] = 16'($urandom); s[pend] = 6'($urandom_range(0, 5));
        set_req(pend, accepts < 4, a[pend], b[pend], s[pend]);
        pend = -1;
      end
      if (accepts >= 4) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        take_exp(e, ok);
        checks++;
        if (!ok || {bus.rsp0_valid, bus.rsp1_valid} !== (e.port ? 2'b01 : 2'b10) ||
            (e.port ? bus.rsp1_result : bus.rsp0_result) !== e.res ||
            (e.port ? bus.rsp1_flags  : bus.rsp0_flags)  !== e.flg) begin
          failures++;
          $display("FAIL rr_rsp got v=%b%b r=%h/%h exp port=%0d r=%h f=%h", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_result, bus.rsp1_result, e.port, e.res, e.flg);
        end
        resps++;
      end
      if (bus.req0_ready || bus.req1_ready) begin
        checks++; if (bus.req0_ready && bus.req1_ready) begin failures++; $display("FAIL rr_onehot got=11 exp=one ready"); end
        pend = bus.req1_ready ? 1 : 0;
        if (accepts < 4) begin
          order[accepts] = pend;
          cyc[accepts]   = c;
        end
        push_exp(pend, a[pend], b[pend], s[pend]);
        accepts++;
      end
      @(negedge clk);
    end
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    checks++; if (resps != 4 || accepts != 4) begin failures++; $display("FAIL rr_progress got acc=%0d rsp=%0d exp 4/4", accepts, resps); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (order[i] != (i % 2)) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, order[i], i % 2); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (cyc[i] - cyc[i-1] != 3) begin failures++; $display("FAIL rr_interval[%0d] got=%0d exp=3", i, cyc[i] - cyc[i-1]); end
      end
    end
    #1;
    checks++; if (op_count_o !== 16'd4) begin failures++; $display("FAIL rr_count got=%0d exp=4", op_count_o); end
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    apply_reset();
    set_req(0, 1'b1, 16'h0003, 16'h0004, SEL_SUB);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", bus.req0_ready); end
    push_exp(0, 16'h0003, 16'h0004, SEL_SUB);
    @(negedge clk);
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1, 1'b1, 16'h1234, 16'h00FF, SEL_OR);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 16'hFFFF) begin failures++; $display("FAIL bp_hold[%0d] got v=%b r=%h exp v=1 r=ffff", i, bus.rsp0_valid, bus.rsp0_result); end
      checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, bus.req0_ready, bus.req1_ready); end
      checks++; if ({alu_a_o, alu_b_o, alu_sel_o} !== {16'h0003, 16'h0004, SEL_SUB}) begin failures++; $display("FAIL bp_alu[%0d] got=%h/%h/%h exp=0003/0004/%h", i, alu_a_o, alu_b_o, alu_sel_o, SEL_SUB); end
      @(negedge clk);
    end
    take_exp(e, ok);
    checks++; if (!ok || bus.rsp0_result !== e.res || bus.rsp0_flags !== e.flg) begin failures++; $display("FAIL bp_rsp got=%h/%h exp=%h/%h", bus.rsp0_result, bus.rsp0_flags, e.res, e.flg); end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    checks++; if (bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin failures++; $display("FAIL bp_release got rdy1=%b v0=%b exp 1/0", bus.req1_ready, bus.rsp0_valid); end
    push_exp(1, 16'h1234, 16'h00FF, SEL_OR);
    @(negedge clk);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    @(negedge clk);
    take_exp(e, ok);
    checks++; if (!ok || bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== e.res || bus.rsp1_flags !== e.flg) begin failures++; $display("FAIL bp_rsp1 got v=%b %h/%h exp v=1 %h/%h", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, e.res, e.flg); end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    checks++; if (op_count_o !== 16'd2) begin failures++; $display("FAIL bp_count got=%0d exp=2", op_count_o); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_req(1, 1'b1, 16'h00F0, 16'h0F00, SEL_OR);
    #1;
    checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", bus.req1_ready); end
    @(negedge clk);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    bus.rsp1_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if ({alu_a_o, alu_b_o, alu_sel_o} !== 38'h0 || op_count_o !== 16'h0) begin failures++; $display("FAIL rmid_clear got=%h/%h/%h cnt=%h exp=0", alu_a_o, alu_b_o, alu_sel_o, op_count_o); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.rsp1_valid !== 1'b0 || bus.rsp1_result !== 16'h0 || op_count_o !== 16'h0) begin failures++; $display("FAIL rmid_no_rsp[%0d] got v=%b r=%h cnt=%h exp 0", i, bus.rsp1_valid, bus.rsp1_result, op_count_o); end
    end
    bus.rsp1_ready = 1'b0;
    set_req(0, 1'b1, 16'h1111, 16'h2222, SEL_CMP);
    set_req(1, 1'b1, 16'h3333, 16'h4444, SEL_ADD);
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_regrant got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
  endtask

  task automatic test_counter_wrap();
    exp_t e; bit ok;
    apply_reset();
    force dut.op_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.op_count_q;
    @(negedge clk);
    #1;
    checks++; if (op_count_o !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=ffff", op_count_o); end
    set_req(1, 1'b1, 16'hF0F0, 16'h0FF0, SEL_CMP);
    push_exp(1, 16'hF0F0, 16'h0FF0, SEL_CMP);
    @(negedge clk);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    @(negedge clk);
    take_exp(e, ok);
    checks++; if (!ok || bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== e.res || bus.rsp1_flags !== e.flg) begin failures++; $display("FAIL wrap_rsp got v=%b %h/%h exp v=1 %h/%h", bus.rsp1_valid, bus.rsp1_result, bus.rsp1_flags, e.res, e.flg); end
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp1_ready = 1'b0;
    #1;
    checks++; if (op_count_o !== 16'h0000) begin failures++; $display("FAIL wrap_count got=%h exp=0000", op_count_o); end
  endtask

  initial begin
    set_req(0, 1'b0, 16'h0, 16'h0, 6'h0);
    set_req(1, 1'b0, 16'h0, 16'h0, 6'h0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    test_reset();
    test_single_add();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
